// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with first-word-fall-through byte FIFO and one-cycle error pulses.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_fifo #(
  parameter int BAUD_DIV   = 139,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uart_rxd,
  output logic [7:0]            rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  frame_err,
  output logic                  overrun,
  output logic [DEPTH_LOG2:0]   level
);
  localparam int          DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [15:0] HALF_M1 = 16'(BAUD_DIV / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  logic [1:0]  sync_q;
  logic        rxd_s;
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        ferr_q, ferr_d, ovr_q, ovr_d;
  logic        stop_ok, par_bad;

  logic [DEPTH_LOG2:0]   wr_ptr_q, rd_ptr_q;
  logic [7:0]            mem_q [DEPTH];
  logic                  empty, full, push, pop;

  assign rxd_s = sync_q[1];

`ifdef UART_RX_PARITY_EN
  logic par_err_q, par_err_d;
  assign par_bad = par_err_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) par_err_q <= 1'b0;
    else     par_err_q <= par_err_d;
`else
  assign par_bad = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    idx_d   = idx_q;
    shift_d = shift_q;
    ferr_d  = 1'b0;
    stop_ok = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d = par_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxd_s) state_d = S_START;
      end
      S_START: if (cnt_q == HALF_M1) begin
        cnt_d = '0;
        // a start bit that is gone by mid-bit is a line glitch
        if (rxd_s) state_d = S_IDLE;
        else begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: if (cnt_q == FULL_M1) begin
        cnt_d          = '0;
        shift_d[idx_q] = rxd_s;
        idx_d          = idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
        if (idx_q == 3'd7) state_d = S_PARITY;
`else
        if (idx_q == 3'd7) state_d = S_STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (cnt_q == FULL_M1) begin
        cnt_d     = '0;
        par_err_d = ^{shift_q, rxd_s};
        state_d   = S_STOP;
      end
`endif
      S_STOP: if (cnt_q == FULL_M1) begin
        cnt_d = '0;
        if (!rxd_s) begin
          ferr_d  = 1'b1;
          state_d = S_WAIT_IDLE;
        end else if (par_bad) begin
          ferr_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          stop_ok = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        cnt_d = '0;
        if (rxd_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], uart_rxd};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  // extra pointer MSB distinguishes full from empty
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                 (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign pop   = rx_ready & ~empty;
  assign push  = stop_ok & (~full | pop);
  assign ovr_d = stop_ok & full & ~pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= shift_q;

  assign rx_data   = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  assign rx_valid  = ~empty;
  assign level     = wr_ptr_q - rd_ptr_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: timing-offset receiver model plus queue-based FIFO model, checked every cycle.
module tb_uart_rx_fifo;
  localparam int B = 16, H = B / 2, DL2 = 2, DEPTH = 1 << DL2;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int STOPOFF = H + (9 + PAR) * B;

  logic clk = 0, rst = 0, uart_rxd = 1, rx_ready = 0;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, overrun;
  logic [DL2:0] level;

  uart_rx_fifo #(.BAUD_DIV(B), .DEPTH_LOG2(DL2)) dut (
    .clk(clk), .rst(rst), .uart_rxd(uart_rxd), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun), .level(level));

  always #5 clk = ~clk;

  int nchk = 0, nerr = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Reference model: receiver expressed as sample instants relative to detection time.
  bit m_p1 = 1, m_p2 = 1, m_ferr = 0, m_ovr = 0, m_parbad = 0;
  int m_mode = 0, m_t0 = 0;
  logic [7:0] m_byte = 0;
  logic [7:0] q[$];
  int n_ferr_seen = 0, n_ovr_seen = 0, rise_cyc = -1;
  bit prev_valid = 0;
  logic [7:0] popped[$];

  always @(negedge clk) begin
    bit rs, push, pop, nf, no;
    int off;
    if (rst) begin
      m_p1 = 1; m_p2 = 1; m_mode = 0; q.delete(); m_ferr = 0; m_ovr = 0;
    end
    check("frame_err", frame_err, m_ferr);
    check("overrun", overrun, m_ovr);
    check("rx_valid", rx_valid, q.size() != 0);
    check("level", level, q.size());
    if (q.size() != 0) check("rx_data", rx_data, q[0]);
    if (frame_err === 1'b1) n_ferr_seen++;
    if (overrun === 1'b1) n_ovr_seen++;
    if (rx_valid === 1'b1 && !prev_valid) rise_cyc = cyc;
    prev_valid = (rx_valid === 1'b1);
    if (!rst) begin
      if (rx_valid === 1'b1 && rx_ready) popped.push_back(rx_data);
      rs = m_p2; m_p2 = m_p1; m_p1 = uart_rxd;
      push = 0; nf = 0; no = 0;
      case (m_mode)
        0: if (!rs) begin m_mode = 1; m_t0 = cyc; m_parbad = 0; end
        1: begin
          off = cyc - m_t0;
          if (off == H) begin
            if (rs) m_mode = 0;
          end else if (off > H && off <= H + 8 * B && (off - H) % B == 0)
            m_byte[(off - H) / B - 1] = rs;
          else if (PAR != 0 && off == H + 9 * B)
            m_parbad = (^m_byte) ^ rs;
          else if (off == STOPOFF) begin
            if (!rs) begin nf = 1; m_mode = 2; end
            else if (m_parbad) begin nf = 1; m_mode = 0; end
            else begin push = 1; m_mode = 0; end
          end
        end
        default: if (rs) m_mode = 0;
      endcase
      pop = rx_ready && q.size() > 0;
      if (push && q.size() == DEPTH && !pop) begin no = 1; push = 0; end
      if (pop) void'(q.pop_front());
      if (push) q.push_back(m_byte);
      m_ferr = nf; m_ovr = no;
    end
  end

  bit rand_rdy = 0;
  int fall_cyc = 0;

  task automatic tick();
    @(posedge clk); #1;
    if (rand_rdy) rx_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic hold(input logic v, input int n);
    uart_rxd = v;
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] d, input int stop_low, input bit flip_par, input bit rdy_at_stop);
    fall_cyc = cyc;
    hold(1'b0, B);
    for (int k = 0; k < 8; k++) hold(d[k], B);
    if (PAR != 0) hold((^d) ^ flip_par, B);
    if (stop_low > 0) hold(1'b0, stop_low * B);
    if (rdy_at_stop) begin
      uart_rxd = 1'b1;
      for (int i = 0; i < B; i++) begin
        rx_ready = (i == 2 + H);
        tick();
      end
    end else hold(1'b1, B);
  endtask

  initial begin
    int f0;
    #2 rst = 1;
    #1;
    check("rst_valid", rx_valid, 0);
    check("rst_level", level, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    repeat (3) @(posedge clk);
    #1 rst = 0;
    hold(1'b1, 10);

    // single byte, latency from pin edge to rx_valid
    rx_ready = 1; rise_cyc = -1; popped.delete();
    send(8'hA5, 0, 0, 0);
    hold(1'b1, 5);
    check("a5_latency", rise_cyc - fall_cyc, (PAR != 0) ? 171 : 155);
    check("a5_count", popped.size(), 1);
    if (popped.size() > 0) check("a5_data", popped[0], 8'hA5);
    check("a5_errs", n_ferr_seen + n_ovr_seen, 0);

    // quarter-bit glitch
    hold(1'b0, B / 4);
    hold(1'b1, 3 * B);
    check("glitch_count", popped.size(), 1);
    check("glitch_ferr", n_ferr_seen, 0);

    // break: stop held low for 3 bit times
    send(8'h3C, 3, 0, 0);
    hold(1'b1, B);
    check("brk_ferr", n_ferr_seen, 1);
    check("brk_level", level, 0);
    check("brk_count", popped.size(), 1);
    send(8'h41, 0, 0, 0);
    hold(1'b1, B);
    check("after_brk_count", popped.size(), 2);
    if (popped.size() == 2) check("after_brk_data", popped[1], 8'h41);
    check("after_brk_ferr", n_ferr_seen, 1);

    // overrun on 5th byte
    rx_ready = 0; popped.delete();
    for (int d = 1; d <= 5; d++) send(8'(d), 0, 0, 0);
    hold(1'b1, 4);
    check("ovr_level", level, 4);
    check("ovr_pulses", n_ovr_seen, 1);
    rx_ready = 1; hold(1'b1, 6); rx_ready = 0;
    check("drain_count", popped.size(), 4);
    for (int i = 0; i < 4 && i < popped.size(); i++) check("drain_data", popped[i], i + 1);

    // pop on the stop-sample cycle of a 5th byte frees the slot
    popped.delete();
    for (int d = 8'h11; d <= 8'h14; d++) send(8'(d), 0, 0, 0);
    check("full_level", level, 4);
    send(8'h55, 0, 0, 1);
    hold(1'b1, 4);
    check("simul_level", level, 4);
    check("simul_ovr", n_ovr_seen, 1);
    check("simul_popped", popped.size(), 1);
    rx_ready = 1; hold(1'b1, 6); rx_ready = 0;
    check("simul_drain", popped.size(), 5);
    if (popped.size() == 5) begin
      check("simul_first", popped[0], 8'h11);
      check("simul_last", popped[4], 8'h55);
    end

    // reset in the middle of data bit 4 with two bytes queued
    popped.delete();
    send(8'h21, 0, 0, 0);
    send(8'h22, 0, 0, 0);
    check("pre_rst_level", level, 2);
    hold(1'b0, B);
    for (int k = 0; k < 4; k++) hold(k[0], B);
    hold(1'b1, B / 2);
    rst = 1;
    #1;
    check("mid_rst_valid", rx_valid, 0);
    check("mid_rst_level", level, 0);
    uart_rxd = 1;
    repeat (2) tick();
    rst = 0;
    hold(1'b1, B);
    rx_ready = 1;
    send(8'h7E, 0, 0, 0);
    hold(1'b1, B);
    check("post_rst_count", popped.size(), 1);
    if (popped.size() == 1) check("post_rst_data", popped[0], 8'h7E);
`ifdef UART_RX_PARITY_EN
    f0 = n_ferr_seen;
    send(8'h7E, 0, 1, 0);
    hold(1'b1, B);
    check("par_ferr", n_ferr_seen - f0, 1);
    check("par_nopush", popped.size(), 1);
    check("par_level", level, 0);
`endif

    // randomized traffic against the model
    rand_rdy = 1;
    for (int n = 0; n < 40; n++) begin
      logic [7:0] d;
      int sl;
      bit fp;
      d  = 8'($urandom);
      sl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
      fp = (PAR != 0) && ($urandom_range(0, 7) == 0);
      send(d, sl, fp, 0);
      hold(1'b1, int'($urandom_range(0, 20)));
    end
    rand_rdy = 0; rx_ready = 1;
    hold(1'b1, 10);
    check("final_level", level, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial receive front end of `top`: it oversamples the asynchronous `uart_rxd` pin and recovers 8N1 bytes, LSB first. It buffers the received bytes in a small FIFO and presents them to the Forth core's key/input path over a valid/ready handshake. Framing and overrun errors are reported as one-cycle pulses. The block sits directly between the `uart_rxd` top-level pin and the core.

## Interface
Parameters:
- `BAUD_DIV`, 139, clock cycles per bit (16 MHz / 115200, rounded); legal range 8..65535
- `DEPTH_LOG2`, 2, FIFO depth = 2^DEPTH_LOG2 entries (default 4); legal range 1..4

Ports:
- `clk`  in  1  single system clock; all logic rising-edge
- `rst`  in  1  asynchronous, active-high reset
- `uart_rxd`  in  1  asynchronous serial line, idle high
- `rx_data`  out  8  head-of-FIFO byte; valid only while `rx_valid`
- `rx_valid`  out  1  FIFO not empty
- `rx_ready`  in  1  consumer accepts the head byte when `rx_valid & rx_ready`
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low
- `overrun`  out  1  one-cycle pulse: complete byte dropped because the FIFO was full
- `level`  out  DEPTH_LOG2+1  current FIFO occupancy

## Operation
- Input path: 2-flop synchronizer; reset value 1. All receiver logic uses the synchronized `rxd_s`.
- Bit counter: 16-bit `baud_cnt`.
- State machine states: IDLE, START, DATA, (PARITY), STOP, WAIT_IDLE.
  - IDLE: when `rxd_s`=0, go to START with `baud_cnt`=0.
  - START: at `baud_cnt`=BAUD_DIV/2-1 (integer division), sample `rxd_s`.
    - If 1, treat it as a glitch and return to IDLE with no pulse.
    - Else reset `baud_cnt` and go to DATA with bit index 0.
  - DATA: sample when `baud_cnt`=BAUD_DIV-1, then reset `baud_cnt`. Shift the sample into bit[index], LSB first. After index 7, go to STOP (or to PARITY when configured).
  - STOP: sample at `baud_cnt`=BAUD_DIV-1.
    - Sample 1: push the byte if the FIFO is not full, otherwise pulse `overrun`. Go to IDLE.
    - Sample 0: pulse `frame_err`, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rxd_s`=1, then go to IDLE. A break condition therefore produces exactly one `frame_err`.
- FIFO:
  - Circular buffer with read/write pointers one bit wider than the address; full/empty are derived from the pointer MSB comparison.
  - Pointers wrap modulo 2^(DEPTH_LOG2+1).
  - `rx_data` is read combinationally from mem[rd_ptr] (first-word fall-through).
  - Push and pop in the same cycle:
    - FIFO non-empty: both take effect, `level` is unchanged.
    - FIFO full: the pop frees the slot, so the push succeeds with no overrun.
    - FIFO empty: only the push occurs; the pop is not possible because `rx_valid`=0.
- Reset mid-frame: the FSM returns to IDLE, the FIFO is emptied, and the partial byte is lost. The first frame after reset must begin with a fresh falling edge.

## Timing
- Reset values: `rx_valid`=0, `rx_data`=mem[0] (don't care), `frame_err`=0, `overrun`=0, `level`=0, FSM=IDLE, pointers=0.
- Pin-to-detect latency: 2 cycles (synchronizer).
- Sampling instants, counted from the first cycle IDLE sees `rxd_s`=0:
  - start bit at cycle BAUD_DIV/2
  - data bit k at BAUD_DIV/2 + (k+1)·BAUD_DIV
  - stop bit at BAUD_DIV/2 + 9·BAUD_DIV (+BAUD_DIV with parity)
- Push happens on the stop-sample edge; `rx_valid` and `level` update the next cycle.
- `frame_err` and `overrun` are registered and asserted for exactly one cycle, in the cycle after the stop sample.
- Pop takes effect on the handshake edge; the next head byte appears the following cycle.
- Tolerance: correct reception for a baud mismatch of ±3% at BAUD_DIV≥16.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - FSM adds a PARITY state after bit 7, sampled at BAUD_DIV-1.
  - Even parity is checked over data+parity. On a mismatch the byte is discarded and `frame_err` pulses at the stop sample. If the stop bit is also bad, only one pulse is produced.
- Undefined: plain 8N1, no PARITY state, no parity logic synthesized.

## Test plan
- BAUD_DIV=16, send 0xA5 8N1, `rx_ready`=1 → `rx_valid` pulses for 1 cycle with `rx_data`=0xA5, exactly 2+8+144+1 cycles after the falling pin edge; no error pulses.
- 0.25-bit low glitch on idle line → no `rx_valid`, no `frame_err`, FSM back in IDLE.
- Send 0x3C with stop bit forced low for 3 bit times → one `frame_err` pulse, `level` stays 0; a following 0x41 is received correctly.
- `rx_ready`=0, send 0x01..0x05 back-to-back with DEPTH_LOG2=2 → `level`=4, one `overrun` pulse on byte 5. Draining yields 0x01,0x02,0x03,0x04.
- FIFO full, `rx_ready` asserted on the exact stop-sample cycle of a 5th byte 0x55 → no `overrun`, `level` stays 4, last entry 0x55.
- Assert `rst` mid data-bit 4 with 2 bytes queued → `rx_valid`=0 and `level`=0 asynchronously. The next full frame 0x7E is received intact. With `UART_RX_PARITY_EN`, also check that a flipped parity bit on 0x7E gives `frame_err` and no push.
